mux_feed_scheduler: RTL

- 4-channel round-robin scheduler directly upstream of the 4-bit 4-to-1 multiplexer.
- Buffers one 4-bit word per channel and drives the multiplexer's four data inputs and select.
- Captures the multiplexer output back into a registered output stage with a valid/ready handshake.
- Gives the lab datapath a sequenced, back-pressured source of multiplexed words.

---
 rtl/mux_feed_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_feed_scheduler.sv
// Round-robin feeder for a 4-to-1 word multiplexer: one buffered word per channel,
// registered select, captured output with valid/ready. Define FIXED_PRIORITY_EN for lowest-index-first arbitration.
module mux_feed_scheduler #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned LAST_INIT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  input  logic [3:0]        in_valid,
  output logic [3:0]        in_ready,
  output logic [DATA_W-1:0] mux_w0,
  output logic [DATA_W-1:0] mux_w1,
  output logic [DATA_W-1:0] mux_w2,
  output logic [DATA_W-1:0] mux_w3,
  output logic [1:0]        mux_sel,
  input  logic [DATA_W-1:0] mux_y,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_chan,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int unsigned NCH = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  state_t            state;
  logic [NCH-1:0]    buf_full;
  logic [NCH-1:0]    accept_c;
  logic [NCH-1:0]    clear_c;
  logic [DATA_W-1:0] buf_q [NCH];
  logic [DATA_W-1:0] din_c [NCH];
  logic [1:0]        grant_c;
`ifndef FIXED_PRIORITY_EN
  logic [1:0]        last_grant;
`endif

  assign din_c[0] = in_data0;
  assign din_c[1] = in_data1;
  assign din_c[2] = in_data2;
  assign din_c[3] = in_data3;

  assign mux_w0 = buf_q[0];
  assign mux_w1 = buf_q[1];
  assign mux_w2 = buf_q[2];
  assign mux_w3 = buf_q[3];

  assign in_ready = ~buf_full;
  assign accept_c = in_valid & ~buf_full;
  // The granted buffer is released in DRIVE; it cannot be written that cycle since it is full.
  assign clear_c  = (state == DRIVE) ? (4'b0001 << mux_sel) : 4'b0000;

  // Arbitration: later loop iterations have higher priority, so scan from the lowest-priority candidate.
  always_comb begin
    grant_c = 2'b00;
`ifdef FIXED_PRIORITY_EN
    for (int i = NCH - 1; i >= 0; i--) begin
      if (buf_full[i]) grant_c = 2'(i);
    end
`else
    for (int k = NCH; k >= 1; k--) begin
      if (buf_full[2'(last_grant + 2'(k))]) grant_c = 2'(last_grant + 2'(k));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      buf_full  <= '0;
      mux_sel   <= 2'b00;
      out_data  <= '0;
      out_chan  <= 2'b00;
      out_valid <= 1'b0;
`ifndef FIXED_PRIORITY_EN
      last_grant <= 2'(LAST_INIT);
`endif
      for (int i = 0; i < NCH; i++) buf_q[i] <= '0;
    end else begin
      buf_full <= (buf_full & ~clear_c) | accept_c;
      for (int i = 0; i < NCH; i++) begin
        if (accept_c[i]) buf_q[i] <= din_c[i];
      end
      case (state)
        IDLE: begin
          if (|buf_full) begin
            mux_sel <= grant_c;
            state   <= DRIVE;
          end
        end
        DRIVE: begin
          out_data  <= mux_y;
          out_chan  <= mux_sel;
          out_valid <= 1'b1;
`ifndef FIXED_PRIORITY_EN
          last_grant <= mux_sel;
`endif
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
